rom_reader: RTL

ROM_READER -- requirements
Module: rom_reader

---
 rtl/rom_reader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/rom_reader.sv
// rom_reader: checks a fixed-value header at the start of a ROM image,
// then streams the remaining payload bytes over a valid/ready interface.
// The ROM is combinational: rom_data answers the registered rom_address
// in the same cycle. All outputs are driven straight from flops.
module rom_reader #(
  parameter int          MAGIC_LEN  = 6,
  parameter logic [7:0]  MAGIC_BYTE = 8'h66
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] rom_address,
  input  logic [15:0] rom_size,
  input  logic [7:0]  rom_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MAGIC  = 3'd1,
    S_STREAM = 3'd2,
    S_FINISH = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  localparam logic [15:0] MAGIC_LEN_W  = 16'(MAGIC_LEN);
  localparam logic [15:0] MAGIC_LAST_W = 16'(MAGIC_LEN - 1);

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // Next-state and datapath decode; every target starts from its hold value.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (start) begin
          addr_d = 16'd0;
          if (rom_size < MAGIC_LEN_W) begin
            // Image cannot even hold the header.
            state_d = S_ERR;
            error_d = 1'b1;
          end else begin
            state_d = S_MAGIC;
            error_d = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MAGIC: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        if (rom_data == MAGIC_BYTE) begin
          addr_d = addr_q + 16'd1;
          if (addr_q == MAGIC_LAST_W) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_MAGIC;
          end
        end else begin
          state_d = S_ERR;
          error_d = 1'b1;
        end
      end

      S_STREAM: begin
        if ((!valid_q || out_ready) && (addr_q < rom_size)) begin
          // Output slot is free (or being drained): take the next byte.
          data_d  = rom_data;
          valid_d = 1'b1;
          last_d  = (addr_q == 16'(rom_size - 16'd1));
          addr_d  = addr_q + 16'd1;
        end else if (valid_q && out_ready) begin
          // Final byte consumed with nothing left to load.
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          // Back-pressure or idle slot: hold everything.
          data_d  = data_q;
          valid_d = valid_q;
          last_d  = last_q;
        end
        // Finish as soon as the image is exhausted and the slot will be empty,
        // so done follows the last accepted byte by one cycle.
        if ((addr_q == rom_size) && !valid_d) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_STREAM;
        end
      end

      S_FINISH: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end

      S_ERR: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        error_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they are registered
  // and line up with the state they describe.
  always_comb begin
    done_d = (state_d == S_FINISH);
    if ((state_d == S_MAGIC) || (state_d == S_STREAM)) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign rom_address = addr_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule
